spi_master: RTL

- Single-clock SPI master: the initiator end of the 32-bit full-duplex SPI frame that the team's SPI slave and control-register path consume.
- Used as the bench/host-side driver and as an on-chip master.
- Accepts one word over a valid/ready handshake, shifts it out MSB first on mosi, and simultaneously captures the slave's miso word.
- Returns the captured word with a 1-cycle valid pulse.
- Fixed SPI mode 0: CPOL=0, CPHA=0.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_clk_div.sv | 48 ++++
 rtl/spi_master.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master.
//   SPI_DATA_W      : default frame width in bits.
//   spi_mst_state_t : master FSM state encoding.
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_mst_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
// Half-period down-counter for the SPI master. It produces one tick per
// HALF_DIV enabled cycles. The count reloads itself on every tick, so
// consecutive half-periods follow each other with no extra cycle.
// Ports:
//   clk      : system clock
//   rst_n    : synchronous active-low reset
//   load     : restart the half-period (wins over en)
//   en       : count this cycle
//   tick     : 1-cycle pulse on terminal count (count == 0 while enabled)
//   pre_tick : the cycle before a tick (count == 1 while enabled)
// ---------------------------------------------------------------------------
module spi_clk_div #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = $clog2(HALF_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    assign tick     = en && (cnt == '0);
    assign pre_tick = en && (cnt == ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= RELOAD;
            end else begin
                cnt <= cnt - ONE;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
// SPI mode 0 (CPOL=0, CPHA=0) master. It accepts one word on a valid/ready
// handshake, shifts it out MSB first on mosi and captures miso into rx_data.
//
// Handshake: a word is taken on any clk edge where tx_valid && tx_ready are
// both high. tx_data must be stable while tx_valid is high, and tx_valid is
// ignored while tx_ready is low. rx_valid is a 1-cycle pulse and has no
// back-pressure. rx_data holds until the next frame completes.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   tx_data/valid/ready : word to transmit, handshake
//   rx_data/rx_valid    : captured word, 1-cycle strobe
//   busy                : high from the handshake until the FSM returns to IDLE
//   sck, cs_n, mosi     : SPI outputs (sck idles low, cs_n active low)
//   miso                : SPI input
//
// Build option: define SPI_MASTER_BURST_EN to also raise tx_ready on the last
// HOLD cycle. A word taken on that cycle keeps cs_n low and starts a new
// frame straight away.
//
// Frame timing: a low half-period in SETUP, then DATA_W high and DATA_W low
// half-periods in XFER (the low half after the last falling edge belongs to
// XFER), then a low half-period in HOLD. cs_n is low for
// HALF_DIV*(2*DATA_W+2) cycles.
// ---------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int HALF_DIV = 4,
    parameter int CS_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sck,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

`ifdef SPI_MASTER_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_SETUP = SETUP;
    localparam logic [2:0] S_XFER  = XFER;
    localparam logic [2:0] S_HOLD  = HOLD;
    localparam logic [2:0] S_GAP   = GAP;

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] PEN_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    logic [2:0]        state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              take;
    logic              div_en;
    logic              tick;
    logic              pre_tick;

    // tx_ready is only ever high in IDLE or, in burst builds, on the last
    // HOLD cycle, so this is the complete acceptance condition.
    assign take   = tx_valid && tx_ready;
    assign div_en = (state == S_SETUP) || (state == S_XFER) || (state == S_HOLD);

    spi_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (take),
        .en       (div_en),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            sck      <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (take) begin
                        tx_sr    <= tx_data;
                        mosi     <= tx_data[DATA_W-1];
                        bit_cnt  <= '0;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        state    <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (tick) begin
                        sck   <= 1'b1;
                        state <= S_XFER;
                    end
                end

                S_XFER: begin
                    if (tick) begin
                        if (sck) begin
                            // Falling edge: capture miso, then present the
                            // next bit unless this was the last one.
                            sck     <= 1'b0;
                            rx_sr   <= {rx_sr[DATA_W-2:0], miso};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt != PEN_BIT) begin
                                tx_sr <= tx_sr << 1;
                                mosi  <= tx_sr[DATA_W-2];
                            end
                        end else if (bit_cnt == LAST_BIT) begin
                            state <= S_HOLD;
                        end else begin
                            sck <= 1'b1;
                        end
                    end
                end

                S_HOLD: begin
                    if (BURST_EN && pre_tick) begin
                        tx_ready <= 1'b1;
                    end
                    if (tick) begin
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        tx_ready <= 1'b0;
                        if (take) begin
                            // Burst continuation: cs_n stays low.
                            tx_sr   <= tx_data;
                            mosi    <= tx_data[DATA_W-1];
                            bit_cnt <= '0;
                            state   <= S_SETUP;
                        end else begin
                            cs_n    <= 1'b1;
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state    <= S_IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
